// File: rtl/veri_io_responder_if.sv
// CPU-side bus of the VeriRISC I/O responder: address, write data, strobes and
// the tri-state style read return (data_out qualified by data_oe).
interface veri_io_responder_if;
  // Strobes are levels that may be held for many cycles. A write takes effect
  // once on the rising edge of wr. A DATA read pops once, the cycle after rd
  // falls. data_out is meaningful only while data_oe is high and is 0 otherwise.
  logic [4:0] addr;
  logic [7:0] data_in;
  logic       rd;
  logic       wr;
  logic [7:0] data_out;
  logic       data_oe;

  modport master (output addr, output data_in, output rd, output wr,
                  input data_out, input data_oe);
  modport slave  (input addr, input data_in, input rd, input wr,
                  output data_out, output data_oe);
endinterface

// File: rtl/veri_io_responder.sv
// Memory-mapped I/O target: a 4-register window bridging CPU accesses to an
// outbound (TX) and an inbound (RX) byte stream through two small FIFOs.
module veri_io_responder #(
  parameter logic [4:0] BASE_ADDR  = 5'h1C,
  parameter int         FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  veri_io_responder_if.slave  bus,
  output logic [7:0]          tx_data,
  output logic                tx_valid,
  input  logic                tx_ready,
  input  logic [7:0]          rx_data,
  input  logic                rx_valid,
  output logic                rx_ready,
  output logic                irq
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    REG_DATA    = 2'd0,
    REG_STATUS  = 2'd1,
    REG_CTRL    = 2'd2,
    REG_SCRATCH = 2'd3
  } reg_idx_e;

  logic     hit;
  reg_idx_e idx;
  logic     wr_q, rd_q, dsel_q;
  logic     wr_ev, rd_ev;
  logic     err, ie;
  logic [7:0] scratch;

  logic [7:0]    tx_mem [FIFO_DEPTH];
  logic [AW-1:0] tx_wptr, tx_rptr;
  logic [CW-1:0] tx_cnt;
  logic          tx_full, tx_empty, tx_push, tx_pop, tx_drop;

  logic [7:0]    rx_mem [FIFO_DEPTH];
  logic [AW-1:0] rx_wptr, rx_rptr;
  logic [CW-1:0] rx_cnt;
  logic          rx_full, rx_nempty, rx_push, rx_pop, rx_under;

  logic       ctrl_wr, flush, err_clr;
  logic [7:0] rd_sel;

  assign hit = (bus.addr[4:2] == BASE_ADDR[4:2]);
  assign idx = reg_idx_e'(bus.addr[1:0]);

  // One event per strobe: rising wr, or the cycle after rd falls on DATA.
  assign wr_ev = bus.wr & ~wr_q & hit;
  assign rd_ev = rd_q & ~bus.rd & dsel_q;

  assign ctrl_wr = wr_ev & (idx == REG_CTRL);
  assign flush   = ctrl_wr & bus.data_in[1];
  assign err_clr = ctrl_wr & bus.data_in[0];

  assign tx_full  = (tx_cnt == FULL_CNT);
  assign tx_empty = (tx_cnt == '0);
  assign tx_push  = wr_ev & (idx == REG_DATA) & ~tx_full;
  assign tx_drop  = wr_ev & (idx == REG_DATA) & tx_full;
  assign tx_pop   = tx_valid & tx_ready;
  assign tx_valid = ~tx_empty;
  assign tx_data  = tx_valid ? tx_mem[tx_rptr] : 8'h00;

  assign rx_full   = (rx_cnt == FULL_CNT);
  assign rx_nempty = (rx_cnt != '0);
  assign rx_ready  = rst & ~rx_full;
  assign rx_push   = rx_valid & rx_ready;
  assign rx_pop    = rd_ev & rx_nempty;
  assign rx_under  = rd_ev & ~rx_nempty;

  assign irq = ie & rx_nempty;

  function automatic logic [CW-1:0] next_cnt(input logic [CW-1:0] cnt,
                                              input logic push, input logic pop);
    logic [CW-1:0] n;
    n = cnt;
    if (push && !pop) n = cnt + CW'(1);
    if (pop && !push) n = cnt - CW'(1);
    return n;
  endfunction

  always_comb begin
    rd_sel = 8'h00;
    case (idx)
      REG_DATA:    rd_sel = rx_nempty ? rx_mem[rx_rptr] : 8'h00;
      REG_STATUS:  rd_sel = {3'b000, err, tx_full, tx_empty, rx_full, rx_nempty};
      REG_CTRL:    rd_sel = {5'b00000, ie, 2'b00};
      REG_SCRATCH: rd_sel = scratch;
    endcase
  end

  assign bus.data_oe  = bus.rd & hit;
  assign bus.data_out = (bus.rd & hit) ? rd_sel : 8'h00;

  // Strobe history resets high so a strobe held through reset release is ignored.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_q    <= 1'b1;
      rd_q    <= 1'b1;
      dsel_q  <= 1'b0;
      tx_wptr <= '0;
      tx_rptr <= '0;
      tx_cnt  <= '0;
      rx_wptr <= '0;
      rx_rptr <= '0;
      rx_cnt  <= '0;
      err     <= 1'b0;
      ie      <= 1'b0;
      scratch <= 8'h00;
    end else begin
      wr_q <= bus.wr;
      rd_q <= bus.rd;
      if (bus.rd) dsel_q <= hit & (idx == REG_DATA);

      if (flush) begin
        tx_wptr <= '0;
        tx_rptr <= '0;
        tx_cnt  <= '0;
        rx_wptr <= '0;
        rx_rptr <= '0;
        rx_cnt  <= '0;
      end else begin
        if (tx_push) tx_wptr <= tx_wptr + AW'(1);
        if (tx_pop)  tx_rptr <= tx_rptr + AW'(1);
        tx_cnt <= next_cnt(tx_cnt, tx_push, tx_pop);
        if (rx_push) rx_wptr <= rx_wptr + AW'(1);
        if (rx_pop)  rx_rptr <= rx_rptr + AW'(1);
        rx_cnt <= next_cnt(rx_cnt, rx_push, rx_pop);
      end

      if (tx_drop || rx_under) err <= 1'b1;
      else if (err_clr)        err <= 1'b0;
      if (ctrl_wr) ie <= bus.data_in[2];
      if (wr_ev && idx == REG_SCRATCH) scratch <= bus.data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && !flush && tx_push) tx_mem[tx_wptr] <= bus.data_in;
    if (rst && !flush && rx_push) rx_mem[rx_wptr] <= rx_data;
  end
endmodule
